// File: rtl/dense_result_reader.sv
// dense_result_reader: captures a packed score vector, runs a sequential signed argmax,
// pulses the winning class and drives the board LEDs (class one-hot or dwell-cycled raw scores).
module dense_result_reader #(
    parameter int N_CLASS   = 7,
    parameter int DATA_BITS = 8,
    parameter int DWELL     = 10000
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           valid_i,
    input  logic [N_CLASS*DATA_BITS-1:0]   data_i,
    input  logic                           mode_i,
    output logic [2:0]                     class_o,
    output logic                           class_valid_o,
    output logic                           busy_o,
    output logic [7:0]                     led_o
);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    typedef enum logic [1:0] {IDLE, SCAN, SHOW} state_t;
    state_t                        r_state, w_state_nxt;
    logic signed [DATA_BITS-1:0]   r_score [N_CLASS];
    logic signed [DATA_BITS-1:0]   r_best, w_best_nxt;
    logic [2:0]                    r_idx, w_idx_nxt, r_best_idx, w_best_idx_nxt;
    logic [2:0]                    w_class_nxt, r_disp, w_disp_nxt;
    logic [CW-1:0]                 r_cnt, w_cnt_nxt;
    logic                          w_capture, w_take, w_done, w_wrap;
    logic [6:0]                    w_onehot;
    logic [7:0]                    w_led_nxt;
    always_comb begin
        w_capture      = (r_state != SCAN) && valid_i;
        w_take         = r_score[r_idx] > r_best;
        w_done         = (r_state == SCAN) && (r_idx == 3'(N_CLASS-1));
        w_wrap         = r_cnt == CW'(DWELL-1);
        w_state_nxt    = r_state;
        w_best_nxt     = r_best;
        w_best_idx_nxt = r_best_idx;
        w_idx_nxt      = r_idx;
        w_class_nxt    = class_o;
        w_disp_nxt     = r_disp;
        w_cnt_nxt      = r_cnt;
        if (w_capture) begin
            w_state_nxt    = SCAN;
            w_best_nxt     = data_i[DATA_BITS-1:0];
            w_best_idx_nxt = 3'd0;
            w_idx_nxt      = 3'd1;
        end else if (r_state == SCAN) begin
            w_best_nxt     = w_take ? r_score[r_idx] : r_best;
            w_best_idx_nxt = w_take ? r_idx : r_best_idx;
            w_idx_nxt      = r_idx + 3'd1;
            if (w_done) begin
                w_state_nxt = SHOW;
                w_class_nxt = w_best_idx_nxt;
                w_disp_nxt  = 3'd0;
                w_cnt_nxt   = '0;
            end
        end else if (r_state == SHOW) begin
            w_cnt_nxt  = w_wrap ? '0 : r_cnt + 1'b1;
            w_disp_nxt = !w_wrap ? r_disp : (r_disp == 3'(N_CLASS-1)) ? 3'd0 : r_disp + 3'd1;
        end
        // LEDs follow the next-cycle class/display index so they change on the same edge
        w_onehot  = 7'(1) << w_class_nxt;
        w_led_nxt = (w_state_nxt == IDLE) ? 8'd0 :
                    mode_i ? 8'(r_score[w_disp_nxt]) : {1'b1, w_onehot};
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_best        <= '0;
            r_best_idx    <= '0;
            r_idx         <= '0;
            r_disp        <= '0;
            r_cnt         <= '0;
            class_o       <= '0;
            class_valid_o <= 1'b0;
            busy_o        <= 1'b0;
            led_o         <= '0;
            for (int k = 0; k < N_CLASS; k++) r_score[k] <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_best        <= w_best_nxt;
            r_best_idx    <= w_best_idx_nxt;
            r_idx         <= w_idx_nxt;
            r_disp        <= w_disp_nxt;
            r_cnt         <= w_cnt_nxt;
            class_o       <= w_class_nxt;
            class_valid_o <= w_done;
            busy_o        <= w_state_nxt == SCAN;
            led_o         <= w_led_nxt;
            if (w_capture)
                for (int k = 0; k < N_CLASS; k++) r_score[k] <= data_i[k*DATA_BITS +: DATA_BITS];
        end
    end
endmodule

// File: tb/tb_dense_result_reader.sv
// tb_dense_result_reader: directed checks of capture, argmax, latency, busy drop, LED modes and reset.
module tb_dense_result_reader;
    logic        clk, resetn, valid_i, mode_i;
    logic [55:0] data_i;
    logic [2:0]  class_o;
    logic        class_valid_o, busy_o;
    logic [7:0]  led_o;
    int          n_vec, n_miss, pulses;

    dense_result_reader #(.N_CLASS(7), .DATA_BITS(8), .DWELL(4)) dut (
        .clk(clk), .resetn(resetn), .valid_i(valid_i), .data_i(data_i), .mode_i(mode_i),
        .class_o(class_o), .class_valid_o(class_valid_o), .busy_o(busy_o), .led_o(led_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] pk(input int a0, a1, a2, a3, a4, a5, a6);
        return {8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    // pulse valid_i for one edge, then run the remaining 6 scan edges
    task automatic scan(input logic [55:0] d);
        data_i = d; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        resetn = 1'b0; valid_i = 1'b0; mode_i = 1'b0; data_i = '0;
        repeat (2) tick();
        resetn = 1'b1;
        chk("rst_class", class_o, 0);
        chk("rst_cv", class_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_led", led_o, 0);

        // basic argmax and latency
        data_i = pk(10, -5, 3, 100, 7, 0, -128); valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        chk("t1_busy0", busy_o, 1);
        chk("t1_cv0", class_valid_o, 0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("t1_busy%0d", k), busy_o, (k < 6) ? 1 : 0);
            chk($sformatf("t1_cv%0d", k), class_valid_o, (k == 6) ? 1 : 0);
        end
        chk("t1_class", class_o, 3);
        chk("t1_led", led_o, 8'h88);
        tick();
        chk("t1_cv_end", class_valid_o, 0);

        // all negative, tie at -1 keeps index 0
        data_i = pk(-1, -2, -128, -1, -3, -4, -5); valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (2) tick();
        chk("t2_led_hold", led_o, 8'h88);
        repeat (4) tick();
        chk("t2_cv", class_valid_o, 1);
        chk("t2_class", class_o, 0);
        chk("t2_led", led_o, 8'h81);

        // valid_i mid-scan is dropped
        data_i = pk(1, 2, 50, 3, 4, 5, 6); valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (2) tick();
        data_i = pk(0, 0, 0, 0, 0, 0, 99); valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (class_valid_o) pulses++;
        end
        chk("t3_pulses", pulses, 1);
        chk("t3_class", class_o, 2);
        chk("t3_led", led_o, 8'h84);

        // recapture from SHOW; LEDs hold the old class until the new pulse
        data_i = pk(0, 1, 2, 3, 4, 120, 5); valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("t4_hold%0d", k), led_o, 8'h84);
            tick();
        end
        chk("t4_cv", class_valid_o, 1);
        chk("t4_class", class_o, 5);
        chk("t4_led", led_o, 8'ha0);

        // score cycling, DWELL=4, wrap after index 6
        mode_i = 1'b1;
        scan(pk(1, 2, 3, 4, 5, 6, 7));
        chk("t5_cv", class_valid_o, 1);
        chk("t5_class", class_o, 6);
        for (int j = 0; j < 32; j++) begin
            chk($sformatf("t5_led%0d", j), led_o, ((j / 4) % 7) + 1);
            tick();
        end
        mode_i = 1'b0;
        tick();
        chk("t5_mode0", led_o, 8'hc0);

        // reset during scan
        data_i = pk(5, 1, 1, 1, 1, 1, 1); valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (2) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("t6_class", class_o, 0);
        chk("t6_cv", class_valid_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_led", led_o, 0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (class_valid_o || busy_o || led_o != 0) pulses++;
        end
        chk("t6_quiet", pulses, 0);
        scan(pk(0, 0, 0, 0, 9, 0, 0));
        chk("t6_cv2", class_valid_o, 1);
        chk("t6_class2", class_o, 4);
        chk("t6_led2", led_o, 8'h90);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
